// File: rtl/audio_pkg.sv
// Shared audio-path constants and types for the I2S buffer and its frame readers.
package audio_pkg;
  localparam int DEFAULT_DATA_WIDTH   = 24;
  localparam int DEFAULT_BUFFER_DEPTH = 512;

  // Skid storage sized to cover the read round trip: one read on the bus,
  // one returning, one held at the output.
  localparam int SKID_DEPTH = 3;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;
endpackage

// File: rtl/buffer_read_sequencer_if.sv
// Frame-reader bus: buffer read port, sample stream and status.
interface buffer_read_sequencer_if #(
  parameter int DATA_WIDTH      = audio_pkg::DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH      = $clog2(audio_pkg::DEFAULT_BUFFER_DEPTH),
  parameter int FRAME_CNT_WIDTH = 16
);
  logic                       i_enable;
  logic                       i_frame_ready;
  logic [ADDR_WIDTH-1:0]      o_read_addr;
  logic [DATA_WIDTH-1:0]      i_read_data;
  logic [DATA_WIDTH-1:0]      o_sample;
  logic                       o_sample_valid;
  logic                       i_sample_ready;
  logic [ADDR_WIDTH-1:0]      o_sample_index;
  logic                       o_sample_last;
  logic                       o_busy;
  logic                       o_frame_done;
  logic                       o_frame_abort;
  logic                       o_overrun;
  logic                       i_clear_overrun;
  logic [FRAME_CNT_WIDTH-1:0] o_frame_count;

  modport master (
    input  i_enable, i_frame_ready, i_read_data, i_sample_ready, i_clear_overrun,
    output o_read_addr, o_sample, o_sample_valid, o_sample_index, o_sample_last,
           o_busy, o_frame_done, o_frame_abort, o_overrun, o_frame_count
  );

  modport slave (
    output i_enable, i_frame_ready, i_read_data, i_sample_ready, i_clear_overrun,
    input  o_read_addr, o_sample, o_sample_valid, o_sample_index, o_sample_last,
           o_busy, o_frame_done, o_frame_abort, o_overrun, o_frame_count
  );
endinterface

// File: rtl/sample_skid_fifo.sv
// Shift-register skid FIFO of {index, last, data}; entry 0 is the registered head.
module sample_skid_fifo
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEFAULT_BUFFER_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [ADDR_WIDTH-1:0] push_index,
  input  logic                  push_last,
  output logic [SKID_CNT_W-1:0] count,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [ADDR_WIDTH-1:0] head_index,
  output logic                  head_last
);
  logic [DATA_WIDTH-1:0] data_q  [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] data_d  [SKID_DEPTH];
  logic [ADDR_WIDTH-1:0] index_q [SKID_DEPTH];
  logic [ADDR_WIDTH-1:0] index_d [SKID_DEPTH];
  logic                  last_q  [SKID_DEPTH];
  logic                  last_d  [SKID_DEPTH];
  logic [SKID_CNT_W-1:0] count_q, count_d, wr_ptr;

  // Pop shifts everything down one slot; push lands just past the surviving entries.
  always_comb begin
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    count_d = count_q;
    wr_ptr  = count_q;
    if (pop && (count_q != '0)) begin
      for (int i = 0; i < SKID_DEPTH - 1; i++) begin
        data_d[i]  = data_q[i+1];
        index_d[i] = index_q[i+1];
        last_d[i]  = last_q[i+1];
      end
      wr_ptr  = count_q - 1'b1;
      count_d = count_q - 1'b1;
    end
    if (push && (32'(wr_ptr) < SKID_DEPTH)) begin
      data_d[wr_ptr]  = push_data;
      index_d[wr_ptr] = push_index;
      last_d[wr_ptr]  = push_last;
      count_d         = count_d + 1'b1;
    end
    if (flush) count_d = '0;
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        data_q[i]  <= '0;
        index_q[i] <= '0;
        last_q[i]  <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  assign count      = count_q;
  assign head_data  = data_q[0];
  assign head_index = index_q[0];
  assign head_last  = last_q[0];
endmodule

// File: rtl/buffer_read_sequencer.sv
// Sweeps the completed bank of the I2S double buffer and streams it to one consumer.
module buffer_read_sequencer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int BUFFER_DEPTH    = DEFAULT_BUFFER_DEPTH,
  parameter int ADDR_WIDTH      = $clog2(BUFFER_DEPTH),
  parameter int FRAME_CNT_WIDTH = 16
) (
  input logic                     clk,
  input logic                     reset,
  buffer_read_sequencer_if.master bus
);
  seq_state_e                 state_q, state_d;
  logic [ADDR_WIDTH:0]        issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH-1:0]      ret_cnt_q, ret_cnt_d;
  logic [1:0]                 vld_pipe_q, vld_pipe_d;
  logic [ADDR_WIDTH-1:0]      read_addr_q, read_addr_d;
  logic                       done_q, done_d;
  logic                       abort_q, abort_d;
  logic                       overrun_q, overrun_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  logic                  fifo_push, fifo_pop, fifo_flush;
  logic [SKID_CNT_W-1:0] fifo_count;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] head_index;
  logic                  head_last;
  logic                  xfer_last, can_issue, start;
  logic [2:0]            outstanding;

  // vld_pipe_q[0]: address on the bus this cycle; [1]: its data is on i_read_data now.
  assign fifo_push = vld_pipe_q[1];
  assign fifo_pop  = (fifo_count != '0) && bus.i_sample_ready;
  assign xfer_last = fifo_pop && head_last;

  // Occupancy after this cycle's pop; a new read is only allowed if a slot is guaranteed.
  assign outstanding = 3'(vld_pipe_q[0]) + 3'(vld_pipe_q[1]) + 3'(fifo_count) - 3'(fifo_pop);
  assign can_issue   = (issue_cnt_q < (ADDR_WIDTH+1)'(BUFFER_DEPTH)) &&
                       (outstanding < 3'(SKID_DEPTH));

  sample_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .push_data  (bus.i_read_data),
    .push_index (ret_cnt_q),
    .push_last  (ret_cnt_q == ADDR_WIDTH'(BUFFER_DEPTH - 1)),
    .count      (fifo_count),
    .head_data  (head_data),
    .head_index (head_index),
    .head_last  (head_last)
  );

  // Sweep control: frame start, read issue, completion and overrun recovery.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    vld_pipe_d  = {vld_pipe_q[0], 1'b0};
    read_addr_d = read_addr_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    fifo_flush  = 1'b0;
    start       = 1'b0;

    if (fifo_push) ret_cnt_d = ret_cnt_q + 1'b1;
    if (bus.i_clear_overrun) overrun_d = 1'b0;

    unique case (state_q)
      IDLE: start = bus.i_frame_ready && bus.i_enable;
      RUN: begin
        if (xfer_last) begin
          // A swap landing with the final transfer is a clean back-to-back frame.
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = IDLE;
          start       = bus.i_frame_ready && bus.i_enable;
        end else if (bus.i_frame_ready) begin
          // Bank swapped under us: drop everything read so far from the old bank.
          overrun_d  = 1'b1;
          abort_d    = 1'b1;
          fifo_flush = 1'b1;
          vld_pipe_d = '0;
          ret_cnt_d  = '0;
          state_d    = IDLE;
          start      = bus.i_enable;
        end else if (can_issue) begin
          vld_pipe_d[0] = 1'b1;
          read_addr_d   = issue_cnt_q[ADDR_WIDTH-1:0];
          issue_cnt_d   = issue_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Starting a sweep issues address 0 on the same edge.
    if (start) begin
      state_d     = RUN;
      vld_pipe_d  = 2'b01;
      read_addr_d = '0;
      issue_cnt_d = (ADDR_WIDTH+1)'(1);
      ret_cnt_d   = '0;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      vld_pipe_q  <= '0;
      read_addr_q <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      read_addr_q <= read_addr_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.o_read_addr    = read_addr_q;
  assign bus.o_sample       = head_data;
  assign bus.o_sample_index = head_index;
  assign bus.o_sample_last  = head_last;
  assign bus.o_sample_valid = (fifo_count != '0);
  assign bus.o_busy         = (state_q == RUN);
  assign bus.o_frame_done   = done_q;
  assign bus.o_frame_abort  = abort_q;
  assign bus.o_overrun      = overrun_q;
  assign bus.o_frame_count  = frame_cnt_q;
endmodule

// File: tb/tb_buffer_read_sequencer.sv
// Scoreboard bench: buffer memory model, expected-sample queue, negedge monitor.
module tb_buffer_read_sequencer;
  localparam int DW = 24, DEPTH = 512, AW = 9, FW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  buffer_read_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_CNT_WIDTH(FW)) bus ();

  buffer_read_sequencer #(
    .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .ADDR_WIDTH(AW), .FRAME_CNT_WIDTH(FW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t       exp_q[$];
  int         n_chk = 0, n_err = 0;
  int         cyc = 0, done_cnt = 0, first_cyc = 0, last_cyc = 0;
  logic [7:0] bank = 8'd0;
  bit         last_prev = 1'b0;

  function automatic logic [DW-1:0] mem_word(logic [7:0] b, logic [AW-1:0] a);
    logic [7:0] hi;
    hi = b * 8'd37 + 8'd1;
    return {hi, ~a[6:0], a};
  endfunction

  // Double-buffer read port: one-cycle registered read of the current bank.
  always @(posedge clk) bus.i_read_data <= mem_word(bank, bus.o_read_addr);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    bit   xfer;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.o_frame_done) begin
        done_cnt++;
        chk("done_after_last", last_prev, 1'b1);
      end
      xfer = bus.o_sample_valid && bus.i_sample_ready;
      if (xfer) begin
        chk("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("data", bus.o_sample, e.data);
          chk("index", bus.o_sample_index, e.idx);
          chk("last", bus.o_sample_last, e.last);
        end
        if (bus.o_sample_index == '0) first_cyc = cyc;
        if (bus.o_sample_last) last_cyc = cyc;
      end
      last_prev = xfer && bus.o_sample_last;
    end
  endtask

  // Pulse frame_ready for one cycle (bank swaps with it) and queue the new frame.
  task automatic start_frame(input bit flush_old, input bit expect_run);
    bus.i_frame_ready = 1'b1;
    bank = bank + 8'd1;
    @(posedge clk); #1;
    bus.i_frame_ready = 1'b0;
    if (flush_old) exp_q.delete();
    if (expect_run)
      for (int i = 0; i < DEPTH; i++)
        exp_q.push_back('{data: mem_word(bank, AW'(i)), idx: AW'(i), last: (i == DEPTH - 1)});
  endtask

  task automatic wait_done(input int target, input bit rnd, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (rnd) bus.i_sample_ready = 1'($urandom_range(0, 1));
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
    chk(tag, ok, 1'b1);
  endtask

  // Returns in the cycle where sample idx is transferring.
  task automatic wait_index(input logic [AW-1:0] idx, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (bus.o_sample_valid && bus.i_sample_ready && bus.o_sample_index == idx) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"},  bus.o_read_addr, 0);
    chk({tag, "_smp"},   bus.o_sample, 0);
    chk({tag, "_vld"},   bus.o_sample_valid, 0);
    chk({tag, "_idx"},   bus.o_sample_index, 0);
    chk({tag, "_last"},  bus.o_sample_last, 0);
    chk({tag, "_busy"},  bus.o_busy, 0);
    chk({tag, "_done"},  bus.o_frame_done, 0);
    chk({tag, "_abort"}, bus.o_frame_abort, 0);
    chk({tag, "_ovr"},   bus.o_overrun, 0);
    chk({tag, "_cnt"},   bus.o_frame_count, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.i_enable        = 1'b0;
    bus.i_frame_ready   = 1'b0;
    bus.i_sample_ready  = 1'b0;
    bus.i_clear_overrun = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    check_zero("post_rst");

    // Single frame, consumer always ready: latency and back-to-back streaming.
    bus.i_enable = 1'b1;
    bus.i_sample_ready = 1'b1;
    start_frame(1'b0, 1'b1);
    chk("lat_addr0", bus.o_read_addr, 0);
    chk("lat_busy", bus.o_busy, 1);
    chk("lat_vld_t1", bus.o_sample_valid, 0);
    @(posedge clk); #1;
    chk("lat_vld_t2", bus.o_sample_valid, 0);
    @(posedge clk); #1;
    chk("lat_vld_t3", bus.o_sample_valid, 1);
    chk("lat_idx_t3", bus.o_sample_index, 0);
    wait_done(1, 1'b0, "done1");
    chk("burst_len", last_cyc - first_cyc, DEPTH - 1);
    chk("cnt1", bus.o_frame_count, 1);
    chk("sb_drained1", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("idle1", bus.o_busy, 0);

    // Backpressure: ten stalled cycles at index 100.
    start_frame(1'b0, 1'b1);
    wait_index(AW'(100), "wait_i100");
    bus.i_sample_ready = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      chk("stall_vld", bus.o_sample_valid, 1);
      chk("stall_idx", bus.o_sample_index, 100);
      chk("stall_data", bus.o_sample, mem_word(bank, AW'(100)));
    end
    chk("stall_max_addr", bus.o_read_addr, 102);
    bus.i_sample_ready = 1'b1;
    wait_done(2, 1'b0, "done2");
    chk("cnt2", bus.o_frame_count, 2);

    // Random backpressure over four frames.
    for (int f = 0; f < 4; f++) begin
      start_frame(1'b0, 1'b1);
      wait_done(3 + f, 1'b1, "done_rnd");
    end
    bus.i_sample_ready = 1'b1;
    chk("cnt_rnd", bus.o_frame_count, 6);
    chk("sb_drained_rnd", exp_q.size(), 0);

    // Overrun: bank swaps while index 300 transfers.
    start_frame(1'b0, 1'b1);
    wait_index(AW'(300), "wait_i300");
    start_frame(1'b1, 1'b1);
    chk("ovr_flag", bus.o_overrun, 1);
    chk("ovr_abort", bus.o_frame_abort, 1);
    chk("ovr_vld", bus.o_sample_valid, 0);
    chk("ovr_busy", bus.o_busy, 1);
    chk("ovr_cnt", bus.o_frame_count, 6);
    chk("ovr_addr0", bus.o_read_addr, 0);
    @(posedge clk); #1;
    chk("ovr_abort_pulse", bus.o_frame_abort, 0);
    wait_done(7, 1'b0, "done_ovr");
    chk("ovr_cnt_after", bus.o_frame_count, 7);
    chk("ovr_sticky", bus.o_overrun, 1);
    bus.i_clear_overrun = 1'b1;
    @(posedge clk); #1;
    bus.i_clear_overrun = 1'b0;
    chk("ovr_cleared", bus.o_overrun, 0);

    // frame_ready coincident with the last transfer: clean completion plus restart.
    start_frame(1'b0, 1'b1);
    wait_index(AW'(DEPTH - 1), "wait_last");
    start_frame(1'b0, 1'b1);
    chk("wl_done", bus.o_frame_done, 1);
    chk("wl_ovr", bus.o_overrun, 0);
    chk("wl_abort", bus.o_frame_abort, 0);
    chk("wl_cnt", bus.o_frame_count, 8);
    chk("wl_busy", bus.o_busy, 1);
    chk("wl_addr0", bus.o_read_addr, 0);
    wait_done(9, 1'b0, "done_wl");
    chk("wl_cnt_after", bus.o_frame_count, 9);
    chk("wl_ovr_after", bus.o_overrun, 0);

    // Disabled: frame_ready ignored, no reads.
    bus.i_enable = 1'b0;
    start_frame(1'b0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("dis_busy", bus.o_busy, 0);
      chk("dis_vld", bus.o_sample_valid, 0);
      chk("dis_addr", bus.o_read_addr, DEPTH - 1);
    end
    chk("dis_cnt", bus.o_frame_count, 9);
    chk("dis_ovr", bus.o_overrun, 0);

    // Enable falling mid-frame: that frame still completes.
    bus.i_enable = 1'b1;
    start_frame(1'b0, 1'b1);
    wait_index(AW'(200), "wait_i200");
    bus.i_enable = 1'b0;
    wait_done(10, 1'b0, "done_en_fall");
    chk("en_fall_cnt", bus.o_frame_count, 10);
    @(posedge clk); #1;
    chk("en_fall_idle", bus.o_busy, 0);

    // Reset in the middle of a sweep.
    bus.i_enable = 1'b1;
    start_frame(1'b0, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero("mid_rst");
    reset = 1'b0;
    exp_q.delete();
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_busy", bus.o_busy, 0);
    end
    chk("rst_no_done", done_cnt, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/buffer_read_sequencer.md
Name: buffer_read_sequencer

Overview:
- Sits between the I2S double buffer and one frame consumer (FFT or lock-in).
- When the buffer reports a completed frame, the block sweeps the read bank from address 0 to BUFFER_DEPTH-1 and absorbs the buffer's 1-cycle registered read latency.
- It streams the samples out over a valid/ready interface with backpressure.
- If the buffer swaps banks before the sweep finishes, it detects the overrun and recovers.

Parameters:
- DATA_WIDTH, 24, sample width; must match the buffer.
- BUFFER_DEPTH, 512, samples per frame; power of two, at least 4.
- ADDR_WIDTH, $clog2(BUFFER_DEPTH), derived; not to be overridden.
- FRAME_CNT_WIDTH, 16, width of the frame counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_enable  in  1  level; allows new frames to start.
- i_frame_ready  in  1  1-cycle pulse from the buffer: bank swapped, new frame readable.
- o_read_addr  out  ADDR_WIDTH  read address to the buffer.
- i_read_data  in  DATA_WIDTH  buffer read data, valid 1 cycle after o_read_addr.
- o_sample  out  DATA_WIDTH  output sample.
- o_sample_valid  out  1  o_sample valid.
- i_sample_ready  in  1  consumer accepts; a transfer occurs when valid and ready are both high.
- o_sample_index  out  ADDR_WIDTH  frame position of o_sample.
- o_sample_last  out  1  high with the sample at index BUFFER_DEPTH-1.
- o_busy  out  1  high while in RUN.
- o_frame_done  out  1  1-cycle pulse after the last sample transfers.
- o_frame_abort  out  1  1-cycle pulse when a partial frame is dropped.
- o_overrun  out  1  sticky overrun flag.
- i_clear_overrun  in  1  clears o_overrun.
- o_frame_count  out  FRAME_CNT_WIDTH  completed frames; wraps modulo 2^FRAME_CNT_WIDTH.

Behaviour:
- Reset values: all outputs 0; state IDLE; skid FIFO empty; issue and return counters 0.
- States: IDLE and RUN.
- IDLE -> RUN when i_frame_ready and i_enable are both high. The issue address is set to 0.
  - When i_frame_ready is high and i_enable is low, the frame is ignored: no flag, no count.
- RUN, read issue:
  - A read is issued (o_read_addr = issue address, which then increments) only while outstanding entries (in flight + stored) are fewer than 3.
  - Skid FIFO depth is 3.
  - No reads are issued past address BUFFER_DEPTH-1.
- Return path: data from each issued read is written into the skid FIFO 1 cycle after issue, tagged with its address.
- Output is registered from the FIFO head:
  - o_sample, o_sample_index and o_sample_last stay stable while o_sample_valid=1 and i_sample_ready=0.
  - o_sample_valid never drops without a transfer, except on abort or reset.
- Latency: with i_frame_ready at cycle T, o_read_addr=0 at T+1 and the first o_sample_valid at T+3.
- Throughput: with i_sample_ready held high, BUFFER_DEPTH samples transfer in consecutive cycles.
- Completion: when the last sample transfers, go to IDLE. On the next cycle, o_frame_done=1 and o_frame_count increments.
- Overrun: i_frame_ready while in RUN, before the last sample has transferred.
  - o_overrun is set (sticky).
  - o_frame_abort pulses the next cycle.
  - The FIFO and in-flight data are discarded; o_sample_valid goes to 0 the next cycle.
  - The sweep restarts at address 0 on the new bank and stays in RUN.
  - o_frame_count does not change.
- i_frame_ready in the same cycle as the last transfer: not an overrun. The frame completes normally (o_frame_done, count increments) and a new frame starts as if from IDLE.
- i_enable falling during RUN: the current frame completes; no new frame starts.
- i_clear_overrun: clears o_overrun. If an overrun occurs in the same cycle, set wins.
- Reset during RUN: returns to IDLE with outputs at reset values; no pulses.

Decomposition:
- Package audio_pkg holds:
  - DATA_WIDTH and BUFFER_DEPTH defaults, shared with the double buffer;
  - the state enum (IDLE, RUN);
  - the constant SKID_DEPTH = 3.
- Sub-module sample_skid_fifo: synchronous 3-entry FIFO of {index, last, data}.
  - Ports: push, pop, flush, count, head outputs.
  - flush has priority over push.

Test Plan:
- Reset, then enable=1, one frame_ready pulse, ready always 1 -> addr 0 at T+1, first valid at T+3, 512 consecutive transfers with indices 0..511, last only at index 511, frame_done once, frame_count=1.
- Consumer holds ready=0 for 10 cycles at index 100 -> o_sample and index 100 stable for those 10 cycles, at most 3 reads outstanding, no data lost or duplicated.
- Random ready (50%) over 4 frames -> every index 0..511 delivered in order per frame, data matches the memory model, frame_count=4.
- Second frame_ready at index 300 -> overrun=1, frame_abort pulse, valid low the next cycle, new sweep from index 0, frame_count unchanged; clear_overrun then drops the flag.
- frame_ready in the same cycle as the last transfer -> frame_done, no overrun, new frame starts at index 0.
- enable=0 with a frame_ready pulse -> stays IDLE, busy=0, no reads issued; reset asserted mid-frame -> all outputs 0 the next cycle.
